// File: rtl/vco_adc_edge_decim.sv
// Edge-counting decimator for a VCO-based ADC front end.
//
// Counts transitions of the sampled VCO phase bit over gapless windows of DECIM samples and
// presents each window's count (saturated to OW bits) through a valid/ready output register.
//
// Ports:
//   clk         sample clock (rising edge)
//   rst_n       asynchronous active-low reset
//   en          conversion enable; low discards any partial window
//   d           sampled VCO phase bit
//   clr_flags   synchronous clear of the sticky ovr/sat flags
//   dout        edge count of the last completed window
//   dout_valid  dout holds an unconsumed result
//   dout_ready  consumer accepts dout when dout_valid && dout_ready
//   ovr         sticky: a completed result was dropped while dout was pending
//   sat         sticky: a window count was clipped at 2^OW-1
module vco_adc_edge_decim #(
  parameter int unsigned DECIM = 64,
  parameter int unsigned OW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          d,
  input  logic          clr_flags,
  output logic [OW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          ovr,
  output logic          sat
);

  localparam int unsigned CW = $clog2(DECIM);
  localparam int unsigned AW = $clog2(DECIM + 1);
  // Accumulator is wide enough for DECIM edges and for the saturation limit.
  localparam int unsigned SW = (AW > OW) ? AW : OW;
  localparam logic [SW-1:0] MaxOut  = SW'({OW{1'b1}});
  localparam logic [CW-1:0] LastCnt = CW'(DECIM - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StAccum
  } state_e;

  state_e        state_q;
  logic          d_prev_q;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] acc_q;
  logic [OW-1:0] dout_q;
  logic          dout_valid_q;
  logic          ovr_q;
  logic          sat_q;

  logic          edge_det;
  logic [SW-1:0] sum;
  logic          complete;
  logic          clip;
  logic [OW-1:0] result;

  always_comb begin
    edge_det = d ^ d_prev_q;
    sum      = acc_q + SW'(edge_det);
    complete = (state_q == StAccum) && en && (cnt_q == LastCnt);
    clip     = (sum > MaxOut);
    result   = clip ? {OW{1'b1}} : sum[OW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      d_prev_q     <= 1'b0;
      cnt_q        <= '0;
      acc_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      ovr_q        <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      // Window datapath: dropping en abandons the partial window immediately.
      if (!en) begin
        state_q <= StIdle;
        acc_q   <= '0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            state_q <= StPrime;
          end
          StPrime: begin
            // Capture the reference phase so the first window has no spurious edge.
            d_prev_q <= d;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= StAccum;
          end
          StAccum: begin
            d_prev_q <= d;
            if (cnt_q == LastCnt) begin
              acc_q <= '0;
              cnt_q <= '0;
            end else begin
              acc_q <= sum;
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end

      // Output register: a new result may replace dout only if the old one is consumed.
      if (complete) begin
        if (!dout_valid_q || dout_ready) begin
          dout_q       <= result;
          dout_valid_q <= 1'b1;
        end
      end else if (dout_valid_q && dout_ready) begin
        dout_valid_q <= 1'b0;
      end

      // Set beats clear when both happen in the same cycle.
      ovr_q <= (ovr_q & ~clr_flags) | (complete & dout_valid_q & ~dout_ready);
      sat_q <= (sat_q & ~clr_flags) | (complete & clip);
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign ovr        = ovr_q;
  assign sat        = sat_q;

endmodule

// File: doc/vco_adc_edge_decim.md
VCO_ADC_EDGE_DECIM -- requirements
Module: vco_adc_edge_decim

Interface
REQ-001 Parameter DECIM, default 64, samples per decimation window (>= 2).
REQ-002 Parameter OW, default 8, output count width.
REQ-003 clk  input  1  sample clock, same clock that captures the VCO phase bit; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 en  input  1  conversion enable; low = idle, partial window discarded.
REQ-006 d  input  1  sampled VCO phase bit, registered output of the upstream flip-flop.
REQ-007 clr_flags  input  1  synchronous clear of the sticky flags.
REQ-008 dout  output  OW  edge count of the last completed window.
REQ-009 dout_valid  output  1  dout holds an unconsumed result.
REQ-010 dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready.
REQ-011 ovr  output  1  sticky; a completed result was dropped because dout was still pending.
REQ-012 sat  output  1  sticky; a window count clipped at 2^OW-1.

Function
REQ-013 The FSM SHALL have states IDLE, PRIME, ACCUM.
REQ-014 IDLE -> PRIME when en=1; PRIME -> ACCUM after exactly one cycle; any state -> IDLE on the cycle en=0.
REQ-015 PRIME SHALL load d into d_prev without counting, so the first window starts from a known phase.
REQ-016 In ACCUM, edge = d XOR d_prev each cycle; d_prev <= d every cycle.
REQ-017 The window counter SHALL count 0..DECIM-1 in ACCUM and wrap to 0 with no idle cycle between windows, so consecutive windows are gapless.
REQ-018 The accumulator SHALL add edge each ACCUM cycle; on the window's last cycle, result = acc + edge, and acc restarts at 0 next cycle.
REQ-019 result SHALL saturate at 2^OW-1; any clipping sets sat.
REQ-020 Completion with dout_valid=0, or dout_valid=1 and dout_ready=1 in the same cycle: dout <= result, dout_valid=1 next cycle (latency 1 clk after the last window sample).
REQ-021 Completion with dout_valid=1 and dout_ready=0: result dropped, dout unchanged, ovr <= 1.
REQ-022 Handshake with no completion: dout_valid <= 0 next cycle; dout keeps its value.
REQ-023 dout and dout_valid SHALL be stable while dout_valid=1 and dout_ready=0.
REQ-024 en=0 mid-window: acc and window counter SHALL clear, and the partial result is discarded; any pending dout/dout_valid is retained until handshake.
REQ-025 clr_flags=1 clears ovr and sat next cycle; if a set condition occurs in the same cycle, set wins.
REQ-026 Maximum edges per window = DECIM; with 2^OW-1 >= DECIM, sat never asserts.

Reset
REQ-027 rst_n=0 SHALL immediately force: state IDLE, d_prev=0, acc=0, window counter=0, dout=0, dout_valid=0, ovr=0, sat=0.
REQ-028 Reset deassertion SHALL be consumed synchronously; the first PRIME occurs no earlier than the first rising edge after rst_n=1 with en=1.
REQ-029 Reset asserted mid-window or with dout pending SHALL discard everything, with no spurious dout_valid after release.

Verification (DECIM=8, OW=4 unless stated)
REQ-030 en=1, d toggling every cycle, dout_ready=1 -> dout=8 every 8 cycles, dout_valid 1-cycle pulses, ovr=0, sat=0.
REQ-031 en=1, d constant 1 -> dout=0 each window; the transition from prime value 0 is not counted if d is already 1 in PRIME.
REQ-032 DECIM=32, OW=4, d toggling -> dout=15, sat=1; clr_flags pulse -> sat=0 next cycle, then sat=1 again at the next window.
REQ-033 dout_ready=0 for 20 cycles with d toggling -> first result held stable, ovr=1 after second completion; dout_ready=1 -> first result delivered once.
REQ-034 Deassert en after 5 cycles of a window, re-enable -> next dout counts only the full new window; no result for the partial window.
REQ-035 Assert rst_n=0 at window cycle 4 with dout_valid=1 -> all outputs 0 immediately; after release, en=1 and 8 toggling samples -> dout=8.
